switch_debounce_mmio: RTL and testbench
=======================================

SWITCH_DEBOUNCE_MMIO -- requirements
Module: switch_debounce_mmio

Purpose: conditions the 24 raw DIP switches before the CPU reads them, and exposes them on the I/O bus as memory-mapped registers.

Interface
REQ-001 The module SHALL have parameter SAMPLE_DIV, default 25000: clk_i cycles per debounce sample tick (minimum 2).
REQ-002 The module SHALL have parameter STABLE_CNT, default 4: number of consecutive differing ticks needed to accept a switch change (minimum 1).
REQ-003 The module SHALL have parameter BASE_ADDR, default 32'hFFFF_F070: address of the switch data register.
REQ-004 clk_i  input  1  CPU clock; the only clock; all state updates on its rising edge.
REQ-005 rst_i  input  1  reset; synchronous and active-high.
REQ-006 switch_i  input  24  raw, asynchronous switch levels.
REQ-007 addr_i  input  32  CPU bus address (ALU result).
REQ-008 we_i  input  1  CPU store enable.
REQ-009 wdata_i  input  32  CPU store data.
REQ-010 rdata_o  output  32  read data; combinational.
REQ-011 sel_o  output  1  high when addr_i hits either register of this block; combinational.
REQ-012 switch_o  output  24  debounced switch levels; registered.
REQ-013 changed_o  output  1  OR of all sticky change bits.

Function
REQ-014 switch_i SHALL pass through a 2-flop synchronizer per bit (sync1, sync2) before any other use.
REQ-015 A tick counter SHALL count 0..SAMPLE_DIV-1 and then wrap to 0; tick is high for the one cycle in which the count equals SAMPLE_DIV-1.
REQ-016 Each bit SHALL have a private stability counter, width clog2(STABLE_CNT+1), updated only on tick:
  - sync2[i]==switch_o[i]: counter cleared.
  - otherwise, counter < STABLE_CNT-1: counter incremented.
  - otherwise (counter reaches STABLE_CNT-1): switch_o[i] takes sync2[i] and the counter clears.
REQ-017 An input bounce that returns to the accepted level before acceptance SHALL clear that bit's counter at the next tick; switch_o SHALL NOT change.
REQ-018 Between ticks, switch_o and all stability counters SHALL hold.
REQ-019 Latency from a clean, stable switch_i edge to switch_o update SHALL be 2 cycles of synchronization, plus the wait to the next tick, plus (STABLE_CNT-1)*SAMPLE_DIV cycles. The total SHALL be at most 2+STABLE_CNT*SAMPLE_DIV cycles.
REQ-020 The sticky change register chg[23:0] SHALL set bit i in the same cycle that switch_o[i] updates (either direction).
REQ-021 A store with we_i=1 and addr_i==BASE_ADDR+4 SHALL clear every chg bit whose wdata_i bit is 1 (write-1-to-clear); wdata_i[31:24] is ignored.
REQ-022 If a set and a W1C clear hit the same chg bit in the same cycle, the set SHALL win.
REQ-023 A store to BASE_ADDR SHALL have no effect (the data register is read-only).
REQ-024 rdata_o SHALL be:
  - {8'b0, switch_o} when addr_i==BASE_ADDR;
  - {8'b0, chg} when addr_i==BASE_ADDR+4;
  - 32'b0 otherwise.
REQ-025 sel_o SHALL be high exactly for addr_i equal to BASE_ADDR or BASE_ADDR+4; no partial decode.
REQ-026 changed_o SHALL equal |chg with no added cycle of delay.
REQ-027 Bus reads SHALL have no side effects.

Reset
REQ-028 While rst_i is high at a clock edge, the following SHALL clear to 0: sync1, sync2, tick counter, all stability counters, switch_o, chg.
REQ-029 While rst_i is high, changed_o SHALL be 0 and rdata_o SHALL still decode combinationally from the cleared state.
REQ-030 Reset asserted mid-debounce SHALL discard all partial progress.
REQ-031 After rst_i deasserts, a switch held high SHALL require the full acceptance sequence before switch_o rises, and SHALL then set the corresponding chg bit.
REQ-032 A W1C store in a cycle where rst_i is high SHALL be ignored.

Verification (all scenarios use SAMPLE_DIV=4, STABLE_CNT=3)
REQ-033 Reset then switch_i=24'h00_0001 held -> switch_o=24'h000001 within 2+12 cycles, not earlier than 2+8 cycles; chg=24'h000001; changed_o=1.
REQ-034 Bit 5 toggles high for 6 cycles then back low -> switch_o[5] stays 0; chg stays 0.
REQ-035 addr_i=32'hFFFF_F074, we_i=1, wdata_i=32'h0000_0001 after REQ-033 -> chg=0 next cycle and changed_o=0; a W1C landing in the same cycle as a new set of that bit -> bit remains 1.
REQ-036 Reads with addr_i=F070 -> rdata_o={8'b0,switch_o}, sel_o=1; addr_i=F074 -> {8'b0,chg}, sel_o=1; addr_i=F060 -> rdata_o=0, sel_o=0; store to F070 -> no state change.
REQ-037 switch_i=24'hFFFFFF, rst_i pulsed one cycle after 2 ticks -> all counters restart; switch_o=24'hFFFFFF only after a full 2+12-cycle window measured from reset release.
REQ-038 All 24 bits change simultaneously to 24'hA5A5A5 -> switch_o updates in one cycle to 24'hA5A5A5; chg=24'hA5A5A5.

Source files
------------

// File: rtl/switch_debounce_mmio_if.sv
`default_nettype none
// ============================================================================
// Module   : switch_debounce_mmio_if
// Purpose  : CPU I/O bus bundle for the switch debounce register block.
//            The master (CPU side) drives the address, store enable and
//            store data. The slave (peripheral) returns the read data and
//            a select flag.
// Signals  : addr_i  [31:0] bus address (ALU result)
//            we_i           store enable
//            wdata_i [31:0] store data
//            rdata_o [31:0] combinational read data
//            sel_o          address hits one of this block's registers
// Revision : 1.0 - initial release
// ============================================================================
interface switch_debounce_mmio_if;
    logic [31:0] addr_i;
    logic        we_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        sel_o;

    modport master (
        output addr_i,
        output we_i,
        output wdata_i,
        input  rdata_o,
        input  sel_o
    );

    modport slave (
        input  addr_i,
        input  we_i,
        input  wdata_i,
        output rdata_o,
        output sel_o
    );
endinterface
`default_nettype wire

// File: rtl/switch_debounce_mmio.sv
`default_nettype none
// ============================================================================
// Module   : switch_debounce_mmio
// Purpose  : Synchronises and debounces 24 raw DIP switches. Exposes the
//            debounced levels and a sticky write-1-to-clear change register
//            on the CPU I/O bus.
// Ports    : clk_i         CPU clock (rising edge)
//            rst_i         synchronous active-high reset
//            switch_i[23:0] raw asynchronous switch levels
//            bus           I/O bus (slave modport)
//            switch_o[23:0] debounced switch levels (registered)
//            changed_o     OR of all sticky change bits
// Registers: BASE_ADDR     read-only  {8'b0, switch_o}
//            BASE_ADDR+4   W1C        {8'b0, chg}
// Revision : 1.0 - initial release
// ============================================================================
module switch_debounce_mmio #(
    parameter int unsigned SAMPLE_DIV = 25000,
    parameter int unsigned STABLE_CNT = 4,
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_F070
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [23:0]                  switch_i,
    switch_debounce_mmio_if.slave        bus,
    output logic [23:0]                  switch_o,
    output logic                         changed_o
);

    localparam int unsigned c_tick_w = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned c_stab_w = $clog2(STABLE_CNT + 1);

    localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(SAMPLE_DIV - 1);
    localparam logic [c_tick_w-1:0] c_tick_one  = c_tick_w'(1);
    localparam logic [c_stab_w-1:0] c_stab_last = c_stab_w'(STABLE_CNT - 1);
    localparam logic [c_stab_w-1:0] c_stab_one  = c_stab_w'(1);
    localparam logic [31:0]         c_chg_addr  = BASE_ADDR + 32'd4;

    logic [23:0]         r_sync1;
    logic [23:0]         r_sync2;
    logic [c_tick_w-1:0] r_tick_cnt;
    logic [23:0]         r_switch;
    logic [23:0]         r_chg;

    logic                w_tick;
    logic [23:0]         w_accept;
    logic [23:0]         w_clr;
    logic                w_hit_data;
    logic                w_hit_chg;
    logic [31:0]         w_rdata;
    logic                w_unused;

    // Two-flop synchroniser; nothing downstream sees switch_i directly.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= switch_i;
            r_sync2 <= r_sync1;
        end
    end

    // Sample tick: one cycle out of every SAMPLE_DIV.
    assign w_tick = (r_tick_cnt == c_tick_last);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + c_tick_one;
        end
    end

    // Per-bit stability counter. It counts ticks on which the synchronised
    // input disagrees with the accepted level. The STABLE_CNT-th consecutive
    // disagreeing tick accepts the new level, and any agreeing tick discards
    // the progress made so far.
    for (genvar gi = 0; gi < 24; gi++) begin : g_bit
        logic [c_stab_w-1:0] r_stab;
        logic                w_differs;

        assign w_differs    = (r_sync2[gi] != r_switch[gi]);
        assign w_accept[gi] = w_tick && w_differs && (r_stab == c_stab_last);

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_stab <= '0;
            end else if (w_tick) begin
                if (!w_differs || (r_stab == c_stab_last)) begin
                    r_stab <= '0;
                end else begin
                    r_stab <= r_stab + c_stab_one;
                end
            end
        end
    end

    // Bus decode: exact match only, so no aliasing.
    assign w_hit_data = (bus.addr_i == BASE_ADDR);
    assign w_hit_chg  = (bus.addr_i == c_chg_addr);
    assign w_clr      = (bus.we_i && w_hit_chg) ? bus.wdata_i[23:0] : 24'h0;

    // The upper store-data byte has no register bits behind it.
    assign w_unused   = ^bus.wdata_i[31:24];

    // Accepted bits load the synchronised level. In chg, the set term is
    // ORed in after the clear, so a change in the same cycle as a W1C of
    // that bit survives.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_switch <= '0;
            r_chg    <= '0;
        end else begin
            r_switch <= (r_switch & ~w_accept) | (r_sync2 & w_accept);
            r_chg    <= (r_chg & ~w_clr) | w_accept;
        end
    end

    always_comb begin
        w_rdata = 32'h0;
        if (w_hit_data) begin
            w_rdata = {8'h0, r_switch};
        end else if (w_hit_chg) begin
            w_rdata = {8'h0, r_chg};
        end
    end

    assign bus.rdata_o = w_rdata;
    assign bus.sel_o   = w_hit_data | w_hit_chg;
    assign switch_o    = r_switch;
    assign changed_o   = |r_chg;

endmodule
`default_nettype wire

// File: tb/tb_switch_debounce_mmio.sv
`default_nettype none
// ============================================================================
// Module   : tb_switch_debounce_mmio
// Purpose  : Directed self-checking bench for switch_debounce_mmio with
//            SAMPLE_DIV=4 and STABLE_CNT=3. Edge numbers in the comments
//            (E1, E2, ...) count rising edges after reset release.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_switch_debounce_mmio;

    localparam logic [31:0] A_DATA = 32'hFFFF_F070;
    localparam logic [31:0] A_CHG  = 32'hFFFF_F074;

    logic        clk;
    logic        rst;
    logic [23:0] sw_in;
    logic [23:0] sw_out;
    logic        changed;

    int n_run;
    int n_fail;

    switch_debounce_mmio_if bus ();

    switch_debounce_mmio #(
        .SAMPLE_DIV (4),
        .STABLE_CNT (3),
        .BASE_ADDR  (32'hFFFF_F070)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .switch_i  (sw_in),
        .bus       (bus.slave),
        .switch_o  (sw_out),
        .changed_o (changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [31:0] a,
                      input logic [31:0] exp_data, input logic exp_sel);
        bus.addr_i = a;
        #1;
        chk({tag, "_rdata"}, bus.rdata_o, exp_data);
        chk({tag, "_sel"}, {31'h0, bus.sel_o}, {31'h0, exp_sel});
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        bus.addr_i  = a;
        bus.wdata_i = d;
        bus.we_i    = 1'b1;
        step(1);
        bus.we_i    = 1'b0;
        bus.wdata_i = 32'h0;
    endtask

    initial begin
        n_run       = 0;
        n_fail      = 0;
        rst         = 1'b1;
        sw_in       = 24'h0;
        bus.addr_i  = 32'h0;
        bus.we_i    = 1'b0;
        bus.wdata_i = 32'h0;

        // Reset state
        step(3);
        chk("rst_switch_o", {8'h0, sw_out}, 32'h0);
        chk("rst_changed", {31'h0, changed}, 32'h0);
        rd("rst_data", A_DATA, 32'h0, 1'b1);
        rd("rst_chg", A_CHG, 32'h0, 1'b1);

        // Single switch held high after reset: ticks at E4, E8, E12, accept at E12
        sw_in = 24'h000001;
        rst   = 1'b0;
        step(11);                                   // E11
        chk("acc_early", {8'h0, sw_out}, 32'h0);
        step(1);                                    // E12
        chk("acc_switch_o", {8'h0, sw_out}, 32'h1);
        chk("acc_changed", {31'h0, changed}, 32'h1);
        rd("acc_chg", A_CHG, 32'h1, 1'b1);

        // Bit 5 bounces high for 6 cycles: reaches count 2 at E20, cleared at E24
        sw_in = 24'h000021;
        step(6);                                    // E18
        sw_in = 24'h000001;
        step(10);                                   // E28
        chk("bounce_switch_o", {8'h0, sw_out}, 32'h1);
        rd("bounce_chg", A_CHG, 32'h1, 1'b1);

        // W1C clears bit 0
        store(A_CHG, 32'h0000_0001);                // E29
        rd("w1c_chg", A_CHG, 32'h0, 1'b1);
        chk("w1c_changed", {31'h0, changed}, 32'h0);

        // Bit 0 falls: ticks E32, E36, accept at E40 coinciding with a W1C
        sw_in = 24'h000000;
        step(10);                                   // E39
        chk("fall_early", {8'h0, sw_out}, 32'h1);
        store(A_CHG, 32'h0000_0001);                // E40
        chk("fall_switch_o", {8'h0, sw_out}, 32'h0);
        rd("setwins_chg", A_CHG, 32'h1, 1'b1);
        chk("setwins_changed", {31'h0, changed}, 32'h1);

        // All bits move to A5A5A5 together: accept at E52
        sw_in = 24'hA5A5A5;
        step(11);                                   // E51
        chk("multi_early", {8'h0, sw_out}, 32'h0);
        step(1);                                    // E52
        chk("multi_switch_o", {8'h0, sw_out}, 32'h00A5A5A5);
        rd("multi_chg", A_CHG, 32'h00A5A5A5, 1'b1);

        // Decode checks
        rd("rd_data", A_DATA, 32'h00A5A5A5, 1'b1);
        rd("rd_miss_lo", 32'hFFFF_F060, 32'h0, 1'b0);
        rd("rd_miss_hi", 32'hFFFF_F078, 32'h0, 1'b0);

        // Partial W1C; upper byte of store data has no effect
        store(A_CHG, 32'hFF00_00A5);                // E53
        rd("w1c_part_chg", A_CHG, 32'h00A5A500, 1'b1);

        // Store to the read-only data register
        store(A_DATA, 32'hFFFF_FFFF);               // E54
        chk("ro_switch_o", {8'h0, sw_out}, 32'h00A5A5A5);
        rd("ro_chg", A_CHG, 32'h00A5A500, 1'b1);

        // All high; counters reach 2 at E64, then reset discards progress
        sw_in = 24'hFFFFFF;
        step(10);                                   // E64
        rst = 1'b1;
        step(1);                                    // E65 reset edge
        chk("rst2_switch_o", {8'h0, sw_out}, 32'h0);
        chk("rst2_changed", {31'h0, changed}, 32'h0);
        rd("rst2_data", A_DATA, 32'h0, 1'b1);
        rd("rst2_chg", A_CHG, 32'h0, 1'b1);
        rst = 1'b0;
        step(11);                                   // relative E11
        chk("rst2_early", {8'h0, sw_out}, 32'h0);
        step(1);                                    // relative E12
        chk("rst2_switch_o_acc", {8'h0, sw_out}, 32'h00FFFFFF);
        rd("rst2_chg_acc", A_CHG, 32'h00FFFFFF, 1'b1);
        chk("rst2_changed_acc", {31'h0, changed}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
